// File: rtl/ex_muldiv_seq.sv
// Multi-cycle multiply/divide for EX: shift-add multiply, restoring divide, signed or unsigned.
// Latency: WIDTH cycles after start is accepted (1 for divide-by-zero, 1 for multiply with MULDIV_FAST_MUL_EN).
// Backpressure: start_i is held until success_o; the result is held in DONE until start_i drops.
module ex_muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 op_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     oprand1_i,
    input  logic [WIDTH-1:0]     oprand2_i,
    input  logic                 cancel_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 success_o,
    output logic                 busy_o,
    output logic                 div_zero_o,
    output logic                 pauseRequest_o
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state_q;
    // hi_q/lo_q hold {remainder, quotient} for divide and {product hi, product lo/multiplier} for multiply
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    // Divisor magnitude for divide, multiplicand magnitude for multiply
    logic [WIDTH-1:0]   opb_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic               dz_q;
    logic [2*WIDTH-1:0] result_q;
    logic               success_q;
    logic               busy_q;
    logic               div_zero_q;

    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic [WIDTH:0]     div_up;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   div_rem_d;
    logic [WIDTH-1:0]   div_quo_d;
    logic [WIDTH-1:0]   div_rem_fix;
    logic [WIDTH-1:0]   div_quo_fix;
    logic [2*WIDTH-1:0] mul_prod_d;
    logic [2*WIDTH-1:0] mul_fix;
`ifndef MULDIV_FAST_MUL_EN
    logic [WIDTH:0]     mul_sum;
`endif

    // Operand magnitudes and one datapath step for each operation, with the signed fix-up applied
    always_comb begin
        abs1 = (signed_i && oprand1_i[WIDTH-1]) ? (WIDTH'(0) - oprand1_i) : oprand1_i;
        abs2 = (signed_i && oprand2_i[WIDTH-1]) ? (WIDTH'(0) - oprand2_i) : oprand2_i;

        // Restoring divide: shift {rem,quot} left, trial-subtract divisor from the upper part
        div_up    = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_up - {1'b0, opb_q};
        div_rem_d = div_diff[WIDTH] ? div_up[WIDTH-1:0] : div_diff[WIDTH-1:0];
        div_quo_d = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        div_quo_fix = neg_res_q ? (WIDTH'(0) - div_quo_d) : div_quo_d;
        div_rem_fix = neg_rem_q ? (WIDTH'(0) - div_rem_d) : div_rem_d;

`ifdef MULDIV_FAST_MUL_EN
        // Whole product in one cycle from the latched magnitudes
        mul_prod_d = {{WIDTH{1'b0}}, opb_q} * {{WIDTH{1'b0}}, lo_q};
`else
        // Shift-add: conditionally add multiplicand to the high half, then shift the pair right
        mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        mul_prod_d = {mul_sum, lo_q[WIDTH-1:1]};
`endif
        mul_fix = neg_res_q ? ((2*WIDTH)'(0) - mul_prod_d) : mul_prod_d;
    end

    // Control FSM and datapath registers; cancel beats start and completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            opb_q      <= '0;
            cnt_q      <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            result_q   <= '0;
            success_q  <= 1'b0;
            busy_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (cancel_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            result_q  <= '0;
            success_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q    <= op_i ? DIV : MUL;
                        busy_q     <= 1'b1;
                        div_zero_q <= 1'b0;
                        cnt_q      <= '0;
                        hi_q       <= '0;
                        dz_q       <= op_i && (oprand2_i == '0);
                        neg_res_q  <= signed_i && (oprand1_i[WIDTH-1] ^ oprand2_i[WIDTH-1]);
                        neg_rem_q  <= signed_i && oprand1_i[WIDTH-1];
                        if (op_i) begin
                            // Zero divisor keeps the raw dividend so it can be returned as HI
                            lo_q  <= (oprand2_i == '0) ? oprand1_i : abs1;
                            opb_q <= abs2;
                        end else begin
                            lo_q  <= abs2;
                            opb_q <= abs1;
                        end
                    end
                end
                MUL: begin
`ifdef MULDIV_FAST_MUL_EN
                    result_q  <= mul_fix;
                    state_q   <= DONE;
                    busy_q    <= 1'b0;
                    success_q <= 1'b1;
`else
                    {hi_q, lo_q} <= mul_prod_d;
                    cnt_q        <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        result_q  <= mul_fix;
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        success_q <= 1'b1;
                    end
`endif
                end
                DIV: begin
                    if (dz_q) begin
                        result_q   <= {lo_q, {WIDTH{1'b1}}};
                        div_zero_q <= 1'b1;
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        success_q  <= 1'b1;
                    end else begin
                        hi_q  <= div_rem_d;
                        lo_q  <= div_quo_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            result_q  <= {div_rem_fix, div_quo_fix};
                            state_q   <= DONE;
                            busy_q    <= 1'b0;
                            success_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!start_i) begin
                        state_q   <= IDLE;
                        success_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result_o       = result_q;
    assign success_o      = success_q;
    assign busy_o         = busy_q;
    assign div_zero_o     = div_zero_q;
    // Stall the pipeline from the request cycle until the result is ready
    assign pauseRequest_o = (state_q == MUL) || (state_q == DIV) ||
                            ((state_q == IDLE) && start_i && !cancel_i);

endmodule
